counter_core: RTL and testbench
===============================

Name: counter_core

Overview:
- Synchronous bounded range counter. Output C walks one step per clock from a start value A toward a terminal value B, then reloads A.
- Direction is set by the relative order of A and B: up when A<=B, down when A>B.
- Used as a programmable sequencer or index generator. A and B are live inputs, sampled every clock.

Parameters:
- WIDTH, 4, bit width of A, B, C and WRAPS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- A  input  WIDTH  start (reload) value, unsigned.
- B  input  WIDTH  terminal value, unsigned.
- C  output  WIDTH  registered count value.
- TC  output  1  terminal count, combinational: 1 when C==B.
- DIR  output  1  combinational direction: 1 = up (A<=B), 0 = down (A>B).
- WRAP  output  1  registered one-cycle pulse: 1 in the cycle after C reloaded A from terminal.
- WRAPS  output  WIDTH  registered saturating count of wraps since reset.

Behaviour:
- Everything is registered on the rising clk edge. No asynchronous paths into state.
- Reset (rst=1 at an edge), with priority over all other actions:
  - C <= A (value present at that edge).
  - WRAP <= 0.
  - WRAPS <= 0.
  - Reset mid-count discards progress and restarts from A on the next edge.
- Normal operation, rules evaluated in priority order each edge (rst=0):
  1. Terminal: if C==B then C <= A, WRAP <= 1, WRAPS <= WRAPS+1 (saturates at 2^WIDTH-1, never wraps to 0).
  2. Out of range: if DIR=1 and (C<A or C>B), or DIR=0 and (C>A or C<B), then C <= A and WRAP <= 0. This is a silent resync with no WRAPS increment; it covers A or B changing mid-run.
  3. Otherwise: C <= C+1 when DIR=1, C <= C-1 when DIR=0, and WRAP <= 0.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - C never passes through the 2^WIDTH boundary, because rules 1 and 2 prevent it (e.g. A=0, B=15 goes 15 -> 0 via reload, not overflow).
- Sequence length and period:
  - Sequence is A, A±1, ..., B, A, ...
  - Period is |B-A|+1 cycles.
  - WRAP pulses once per period, in the cycle C==A following a terminal.
- A==B:
  - C holds at A, TC=1 constantly.
  - Rule 1 fires every edge, so WRAP=1 every cycle after the first edge and WRAPS increments every edge until saturating.
- TC and DIR are pure combinational functions of C, A, B. They are valid in the same cycle as any input change.
- No enable and no latency beyond one clock per step. C is visible at the output immediately after the edge.

Test Plan:
- Full range up, WIDTH=4: rst=1 for one edge with A=0, B=15, then release.
  - C = 0,1,...,15,0,1,...
  - TC=1 only while C=15.
  - WRAP=1 in the cycle C returns to 0.
  - WRAPS=1 after the first wrap, 2 after the second.
- Up sub-range: A=3, B=12 (B=~A) after reset.
  - C = 3..12 then 3.
  - DIR=1, period 10.
  - WRAPS increments once per period.
- Down range: A=9, B=6 after reset.
  - C = 9,8,7,6,9,8...
  - DIR=0, TC at 6.
  - WRAP pulse at each return to 9.
- Degenerate: A=5, B=5 after reset.
  - C stays 5, TC=1, WRAP=1 every cycle.
  - WRAPS counts 1,2,...,15 and holds at 15.
- Mid-run range change: counting with A=0, B=15; at C=10 change to A=2, B=6.
  - Next C=2, then 3,4,5,6,2.
  - No WRAP pulse and no WRAPS increment on the resync edge.
- Reset mid-operation: A=0, B=15 with C=7 and WRAPS=3; assert rst for one edge.
  - C=0, WRAP=0, WRAPS=0.
  - Counting resumes 1,2,... on the following edges.

Source files
------------

// File: rtl/counter_core_if.sv
// Bus bundle for counter_core: range inputs from the controller and count/status outputs back.
interface counter_core_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             TC;
  logic             DIR;
  logic             WRAP;
  logic [WIDTH-1:0] WRAPS;

  modport master (
    output A, B,
    input  C, TC, DIR, WRAP, WRAPS
  );

  modport slave (
    input  A, B,
    output C, TC, DIR, WRAP, WRAPS
  );
endinterface

// File: rtl/counter_core.sv
// Bounded range counter: walks C from A toward B one step per clock, reloading A at the terminal.
// Direction follows the order of A and B, and a saturating counter tracks completed wraps.
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  counter_core_if.slave  bus
);

  localparam logic [WIDTH-1:0] WrapsMax = '1;

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] wrapCount;
  logic             wrapPulse;
  logic             countUp;
  logic             atTerminal;
  logic             outOfRange;

  // Direction, terminal and range status depend only on the live A/B and the current count,
  // so a mid-run change of A or B is seen in the same cycle.
  always_comb begin
    countUp    = 1'b0;
    atTerminal = 1'b0;
    outOfRange = 1'b0;
    countUp    = (bus.A <= bus.B);
    atTerminal = (count == bus.B);
    if (countUp) begin
      outOfRange = (count < bus.A) || (count > bus.B);
    end else begin
      outOfRange = (count > bus.A) || (count < bus.B);
    end
  end

  // Terminal reload wins over resync; resync is silent so only genuine terminals count as wraps.
  // The range checks keep the step from ever crossing the 2^WIDTH boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= bus.A;
      wrapPulse <= 1'b0;
      wrapCount <= '0;
    end else if (atTerminal) begin
      count     <= bus.A;
      wrapPulse <= 1'b1;
      if (wrapCount != WrapsMax) begin
        wrapCount <= wrapCount + 1'b1;
      end
    end else if (outOfRange) begin
      count     <= bus.A;
      wrapPulse <= 1'b0;
    end else begin
      wrapPulse <= 1'b0;
      if (countUp) begin
        count <= count + 1'b1;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign bus.C     = count;
  assign bus.TC    = atTerminal;
  assign bus.DIR   = countUp;
  assign bus.WRAP  = wrapPulse;
  assign bus.WRAPS = wrapCount;

endmodule

// File: tb/tb_counter_core.sv
// Directed bench for counter_core: each scenario task drives A/B/rst and compares against
// hand-derived sequences.
module tb_counter_core;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  counter_core_if #(.WIDTH(4)) bus ();

  counter_core #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it before anyone samples or drives.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [3:0] a, input logic [3:0] b);
    bus.A = a;
    bus.B = b;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    doReset(4'd0, 4'd15);
    checks++; if (bus.C !== 4'd0) begin errors++; $display("[TB] FAIL reset_c: got %0d expected 0", bus.C); end
    checks++; if (bus.WRAP !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap: got %0d expected 0", bus.WRAP); end
    checks++; if (bus.WRAPS !== 4'd0) begin errors++; $display("[TB] FAIL reset_wraps: got %0d expected 0", bus.WRAPS); end
    checks++; if (bus.DIR !== 1'b1) begin errors++; $display("[TB] FAIL reset_dir: got %0d expected 1", bus.DIR); end
    checks++; if (bus.TC !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc: got %0d expected 0", bus.TC); end
  endtask

  task automatic test_full_up();
    logic [3:0] expC;
    logic       expWrap;
    logic [3:0] expWraps;
    doReset(4'd0, 4'd15);
    expWraps = 4'd0;
    for (int i = 1; i <= 33; i++) begin
      tick();
      expC    = 4'(i % 16);
      expWrap = (expC == 4'd0);
      if (expWrap) expWraps = expWraps + 4'd1;
      checks++; if (bus.C !== expC) begin errors++; $display("[TB] FAIL full_up_c step %0d: got %0d expected %0d", i, bus.C, expC); end
      checks++; if (bus.TC !== (expC == 4'd15)) begin errors++; $display("[TB] FAIL full_up_tc step %0d: got %0d expected %0d", i, bus.TC, (expC == 4'd15)); end
      checks++; if (bus.WRAP !== expWrap) begin errors++; $display("[TB] FAIL full_up_wrap step %0d: got %0d expected %0d", i, bus.WRAP, expWrap); end
      checks++; if (bus.WRAPS !== expWraps) begin errors++; $display("[TB] FAIL full_up_wraps step %0d: got %0d expected %0d", i, bus.WRAPS, expWraps); end
    end
    checks++; if (bus.WRAPS !== 4'd2) begin errors++; $display("[TB] FAIL full_up_total: got %0d expected 2", bus.WRAPS); end
  endtask

  task automatic test_up_sub();
    logic [3:0] expC;
    doReset(4'd3, 4'd12);
    checks++; if (bus.C !== 4'd3) begin errors++; $display("[TB] FAIL up_sub_start: got %0d expected 3", bus.C); end
    for (int i = 1; i <= 21; i++) begin
      tick();
      expC = 4'(3 + (i % 10));
      checks++; if (bus.C !== expC) begin errors++; $display("[TB] FAIL up_sub_c step %0d: got %0d expected %0d", i, bus.C, expC); end
      checks++; if (bus.DIR !== 1'b1) begin errors++; $display("[TB] FAIL up_sub_dir step %0d: got %0d expected 1", i, bus.DIR); end
      checks++; if (bus.WRAP !== ((i % 10) == 0)) begin errors++; $display("[TB] FAIL up_sub_wrap step %0d: got %0d expected %0d", i, bus.WRAP, ((i % 10) == 0)); end
      checks++; if (bus.WRAPS !== 4'(i / 10)) begin errors++; $display("[TB] FAIL up_sub_wraps step %0d: got %0d expected %0d", i, bus.WRAPS, i / 10); end
    end
  endtask

  task automatic test_down();
    logic [3:0] expC;
    doReset(4'd9, 4'd6);
    checks++; if (bus.C !== 4'd9) begin errors++; $display("[TB] FAIL down_start: got %0d expected 9", bus.C); end
    checks++; if (bus.DIR !== 1'b0) begin errors++; $display("[TB] FAIL down_dir: got %0d expected 0", bus.DIR); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      expC = 4'(9 - (i % 4));
      checks++; if (bus.C !== expC) begin errors++; $display("[TB] FAIL down_c step %0d: got %0d expected %0d", i, bus.C, expC); end
      checks++; if (bus.TC !== (expC == 4'd6)) begin errors++; $display("[TB] FAIL down_tc step %0d: got %0d expected %0d", i, bus.TC, (expC == 4'd6)); end
      checks++; if (bus.WRAP !== ((i % 4) == 0)) begin errors++; $display("[TB] FAIL down_wrap step %0d: got %0d expected %0d", i, bus.WRAP, ((i % 4) == 0)); end
      checks++; if (bus.WRAPS !== 4'(i / 4)) begin errors++; $display("[TB] FAIL down_wraps step %0d: got %0d expected %0d", i, bus.WRAPS, i / 4); end
    end
  endtask

  task automatic test_degenerate();
    logic [3:0] expWraps;
    doReset(4'd5, 4'd5);
    checks++; if (bus.C !== 4'd5) begin errors++; $display("[TB] FAIL degen_start: got %0d expected 5", bus.C); end
    checks++; if (bus.TC !== 1'b1) begin errors++; $display("[TB] FAIL degen_tc0: got %0d expected 1", bus.TC); end
    checks++; if (bus.WRAP !== 1'b0) begin errors++; $display("[TB] FAIL degen_wrap0: got %0d expected 0", bus.WRAP); end
    for (int i = 1; i <= 20; i++) begin
      tick();
      expWraps = (i > 15) ? 4'd15 : 4'(i);
      checks++; if (bus.C !== 4'd5) begin errors++; $display("[TB] FAIL degen_c step %0d: got %0d expected 5", i, bus.C); end
      checks++; if (bus.TC !== 1'b1) begin errors++; $display("[TB] FAIL degen_tc step %0d: got %0d expected 1", i, bus.TC); end
      checks++; if (bus.WRAP !== 1'b1) begin errors++; $display("[TB] FAIL degen_wrap step %0d: got %0d expected 1", i, bus.WRAP); end
      checks++; if (bus.WRAPS !== expWraps) begin errors++; $display("[TB] FAIL degen_wraps step %0d: got %0d expected %0d", i, bus.WRAPS, expWraps); end
    end
  endtask

  task automatic test_mid_change();
    logic [3:0] expSeq [5];
    expSeq = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd2};
    doReset(4'd0, 4'd15);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bus.C !== 4'd10) begin errors++; $display("[TB] FAIL mid_pre_c: got %0d expected 10", bus.C); end
    bus.A = 4'd2;
    bus.B = 4'd6;
    #1;
    checks++; if (bus.DIR !== 1'b1) begin errors++; $display("[TB] FAIL mid_dir: got %0d expected 1", bus.DIR); end
    checks++; if (bus.TC !== 1'b0) begin errors++; $display("[TB] FAIL mid_tc: got %0d expected 0", bus.TC); end
    tick();
    checks++; if (bus.C !== 4'd2) begin errors++; $display("[TB] FAIL mid_resync_c: got %0d expected 2", bus.C); end
    checks++; if (bus.WRAP !== 1'b0) begin errors++; $display("[TB] FAIL mid_resync_wrap: got %0d expected 0", bus.WRAP); end
    checks++; if (bus.WRAPS !== 4'd0) begin errors++; $display("[TB] FAIL mid_resync_wraps: got %0d expected 0", bus.WRAPS); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.C !== expSeq[i]) begin errors++; $display("[TB] FAIL mid_seq_c step %0d: got %0d expected %0d", i, bus.C, expSeq[i]); end
      checks++; if (bus.WRAP !== (i == 4)) begin errors++; $display("[TB] FAIL mid_seq_wrap step %0d: got %0d expected %0d", i, bus.WRAP, (i == 4)); end
    end
    checks++; if (bus.WRAPS !== 4'd1) begin errors++; $display("[TB] FAIL mid_final_wraps: got %0d expected 1", bus.WRAPS); end
  endtask

  task automatic test_reset_mid();
    doReset(4'd0, 4'd15);
    for (int i = 0; i < 55; i++) tick();
    checks++; if (bus.C !== 4'd7) begin errors++; $display("[TB] FAIL rmid_pre_c: got %0d expected 7", bus.C); end
    checks++; if (bus.WRAPS !== 4'd3) begin errors++; $display("[TB] FAIL rmid_pre_wraps: got %0d expected 3", bus.WRAPS); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.C !== 4'd0) begin errors++; $display("[TB] FAIL rmid_c: got %0d expected 0", bus.C); end
    checks++; if (bus.WRAP !== 1'b0) begin errors++; $display("[TB] FAIL rmid_wrap: got %0d expected 0", bus.WRAP); end
    checks++; if (bus.WRAPS !== 4'd0) begin errors++; $display("[TB] FAIL rmid_wraps: got %0d expected 0", bus.WRAPS); end
    tick();
    checks++; if (bus.C !== 4'd1) begin errors++; $display("[TB] FAIL rmid_resume1: got %0d expected 1", bus.C); end
    tick();
    checks++; if (bus.C !== 4'd2) begin errors++; $display("[TB] FAIL rmid_resume2: got %0d expected 2", bus.C); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.A  = 4'd0;
    bus.B  = 4'd15;
    test_reset();
    test_full_up();
    test_up_sub();
    test_down();
    test_degenerate();
    test_mid_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
